ser8_tx_sched: RTL

- Transmit-side scheduler for the 8-bit serdes path. Two parallel byte sources share a single 8-bit holding latch and bit-serial output.
- Round-robin arbitration picks one source at a time. The block pulses the latch enable, then shifts the byte out MSB-first over 8 clocks. An optional idle gap follows each byte.
- Sits between the byte producers and the 8-bit latch / line driver.

---
 rtl/ser8_tx_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ser8_tx_sched.sv
// ----------------------------------------------------------------------------
// ser8_tx_sched
//   Transmit-side scheduler for the 8-bit serdes path. Two byte sources are
//   round-robin arbitrated onto one holding latch and one bit-serial line.
//   An accepted byte is presented on latch_data, latch_en pulses for one
//   cycle (LOAD), then the byte is shifted out MSB-first over 8 cycles
//   (SHIFT), followed by GAP_CYCLES idle cycles (GAP) before the next accept.
//
// Parameters
//   DATA_W     : byte width, fixed at 8
//   GAP_CYCLES : idle cycles after each byte's last bit (0..15)
//
// Ports
//   clk, rst                 : clock (rising edge), async active-high reset
//   req0_valid/data/ready    : source 0 byte handshake
//   req1_valid/data/ready    : source 1 byte handshake
//   latch_en                 : one-cycle data enable to the external latch
//   latch_data               : byte presented to the latch (held until next accept)
//   ser_out, ser_sync        : serial bit, and marker on the first (MSB) bit
//   grant_id                 : source of the byte in flight
//   busy                     : high whenever the scheduler is not idle
// ----------------------------------------------------------------------------
module ser8_tx_sched #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              latch_en,
    output logic [DATA_W-1:0] latch_data,
    output logic              ser_out,
    output logic              ser_sync,
    output logic              grant_id,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Last gap cycle index; unreachable value when there is no gap.
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t              state_reg;
    state_t              state_next;
    logic                last_grant_reg;
    logic [DATA_W-1:0]   shift_reg;
    logic [2:0]          bit_cnt_reg;
    logic [3:0]          gap_cnt_reg;

    logic [1:0]          src_valid;
    logic [1:0]          src_ready;
    logic                grant_sel;
    logic                accept;
    logic [DATA_W-1:0]   accept_data;

    assign src_valid = {req1_valid, req0_valid};

    // Round-robin: with both sources valid the one not served last wins;
    // otherwise whichever single source is valid (source 1 only when it is
    // the one asking).
    assign grant_sel = (req0_valid && req1_valid) ? ~last_grant_reg : req1_valid;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign src_ready[gi] = (state_reg == IDLE) && src_valid[gi] &&
                                   (grant_sel == 1'(gi));
        end
    endgenerate

    assign req0_ready  = src_ready[0];
    assign req1_ready  = src_ready[1];
    assign accept      = |src_ready;
    assign accept_data = grant_sel ? req1_data : req0_data;

    // Line-side outputs decode straight from the state so that an async
    // reset drops them immediately.
    assign busy     = (state_reg != IDLE);
    assign latch_en = (state_reg == LOAD);
    assign ser_out  = (state_reg == SHIFT) ? shift_reg[bit_cnt_reg] : 1'b0;
    assign ser_sync = (state_reg == SHIFT) && (bit_cnt_reg == 3'd7);

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt_reg == 3'd0) begin
                    state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath: capture on accept, bit and gap counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 1'b1;   // source 0 wins the first contention
            latch_data     <= '0;
            shift_reg      <= '0;
            grant_id       <= 1'b0;
            bit_cnt_reg    <= 3'd0;
            gap_cnt_reg    <= 4'd0;
        end else begin
            if (accept) begin
                latch_data     <= accept_data;
                shift_reg      <= accept_data;
                grant_id       <= grant_sel;
                last_grant_reg <= grant_sel;
            end
            case (state_reg)
                LOAD: begin
                    bit_cnt_reg <= 3'd7;
                end
                SHIFT: begin
                    // Wraps 0 -> 7 on the last bit; the value is unused after.
                    bit_cnt_reg <= bit_cnt_reg - 3'd1;
                    gap_cnt_reg <= 4'd0;
                end
                GAP: begin
                    gap_cnt_reg <= gap_cnt_reg + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
